// File: rtl/micro_ucr_nonce_search.sv
// Nonce search initiator for the hash engine: builds header+nonce blocks, pulses the
// hash start, waits the fixed latency and checks hash bytes 0/1 against a target.
module micro_ucr_nonce_search #(
   parameter int unsigned HASH_LAT    = 32,
   parameter logic [31:0] NONCE_START = 32'h0000_0000,
   parameter logic [31:0] NONCE_MAX   = 32'hFFFF_FFFF
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_start,
   input  logic          i_abort,
   input  logic [95:0]   i_header,
   input  logic [7:0]    i_target,
   input  logic [7:0]    i_hash_in0,
   input  logic [7:0]    i_hash_in1,
   input  logic [7:0]    i_hash_in2,
   output logic [127:0]  o_block_out,
   output logic          o_hash_ready,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_found,
   output logic [31:0]   o_nonce_out,
   output logic [23:0]   o_hash_out,
   output logic [2:0]    o_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   localparam logic [5:0] LP_WAIT_LAST = 6'(HASH_LAT - 1);

   state_t         r_state;
   logic [127:0]   r_block;
   logic [31:0]    r_nonce;
   logic [5:0]     r_wait_cnt;
   logic           r_hash_ready;
   logic           r_busy;
   logic           r_done;
   logic           r_found;
   logic [31:0]    r_nonce_out;
   logic [23:0]    r_hash_out;

   logic           w_hit;
   logic           w_exhausted;
   logic [31:0]    w_next_nonce;

   // Nonce occupies block bytes 12..15 most-significant byte first.
   function automatic logic [31:0] nonce_bytes(input logic [31:0] n);
      return {n[7:0], n[15:8], n[23:16], n[31:24]};
   endfunction

   assign w_hit        = (i_hash_in0 < i_target) && (i_hash_in1 < i_target);
   // ">=" also ends the search after one attempt when NONCE_START lies beyond NONCE_MAX.
   assign w_exhausted  = (r_nonce >= NONCE_MAX);
   assign w_next_nonce = r_nonce + 32'd1;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= S_IDLE;
         r_block      <= '0;
         r_nonce      <= NONCE_START;
         r_wait_cnt   <= '0;
         r_hash_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_found      <= 1'b0;
         r_nonce_out  <= '0;
         r_hash_out   <= '0;
      end else if (i_abort) begin
         r_state      <= S_IDLE;
         r_hash_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_found      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_FIN: begin
               if (i_start) begin
                  r_block      <= {nonce_bytes(NONCE_START), i_header};
                  r_nonce      <= NONCE_START;
                  r_done       <= 1'b0;
                  r_found      <= 1'b0;
                  r_hash_ready <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_hash_ready <= 1'b0;
               r_wait_cnt   <= '0;
               r_state      <= S_WAIT;
            end
            S_WAIT: begin
               r_wait_cnt <= r_wait_cnt + 6'd1;
               if (r_wait_cnt == LP_WAIT_LAST) begin
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_hit) begin
                  r_nonce_out <= r_nonce;
                  r_hash_out  <= {i_hash_in2, i_hash_in1, i_hash_in0};
                  r_found     <= 1'b1;
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_FIN;
               end else if (w_exhausted) begin
                  r_nonce_out <= NONCE_MAX;
                  r_hash_out  <= {i_hash_in2, i_hash_in1, i_hash_in0};
                  r_found     <= 1'b0;
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_FIN;
               end else begin
                  r_nonce         <= w_next_nonce;
                  r_block[127:96] <= nonce_bytes(w_next_nonce);
                  r_hash_ready    <= 1'b1;
                  r_state         <= S_LOAD;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_hash_ready <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   // An abort arriving during LOAD must suppress that cycle's start pulse.
   assign o_hash_ready = r_hash_ready & ~i_abort;
   assign o_block_out  = r_block;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_found      = r_found;
   assign o_nonce_out  = r_nonce_out;
   assign o_hash_out   = r_hash_out;
   assign o_state      = r_state;

endmodule
